// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: instruction classes, opcodes and the
// decoded bundle held in the output pipeline register.
package decode_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;

  typedef enum logic [3:0] {
    TYPE_INVALID = 4'd0,
    TYPE_R       = 4'd1,
    TYPE_I       = 4'd2,
    TYPE_I_MEM   = 4'd3,
    TYPE_S       = 4'd4,
    TYPE_B       = 4'd5,
    TYPE_U       = 4'd6,
    TYPE_J       = 4'd7
  } instr_type_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    instr_type_t       itype;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic              is_write;
    logic              is_branch;
    logic              is_jump;
    logic              is_mem_read;
    logic              is_mem_write;
    logic              is_illegal;
  } decoded_t;

  // Opcodes with low bits other than 2'b11 fall through to TYPE_INVALID.
  function automatic instr_type_t opcode_type(input logic [OP_W-1:0] op);
    instr_type_t t;
    case (op)
      OP_LOAD:                     t = TYPE_I_MEM;
      OP_IMM, OP_JALR:             t = TYPE_I;
      OP_FENCE, OP_SYSTEM:         t = TYPE_I;
      OP_REG:                      t = TYPE_R;
      OP_STORE:                    t = TYPE_S;
      OP_BRANCH:                   t = TYPE_B;
      OP_LUI, OP_AUIPC:            t = TYPE_U;
      OP_JAL:                      t = TYPE_J;
      default:                     t = TYPE_INVALID;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_pipe_imm_gen.sv
// Combinational immediate generator: sign-extended immediate for each RV32I format.
module imm_gen
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  instr_type_t     type_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (type_i)
      TYPE_I, TYPE_I_MEM: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      TYPE_S:             imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      TYPE_B:             imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                   instr_i[30:25], instr_i[11:8], 1'b0};
      TYPE_U:             imm_o = {instr_i[31:12], 12'b0};
      TYPE_J:             imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                   instr_i[20], instr_i[30:21], 1'b0};
      default:            imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// RV32I decode stage with one registered output slot, valid/ready flow control,
// flush and load-use bubble insertion.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned PC_WIDTH      = 32,
  parameter int unsigned HAZARD_DETECT = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output instr_type_t          out_type,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic [REG_AW-1:0]    out_rs1,
  output logic [REG_AW-1:0]    out_rs2,
  output logic [REG_AW-1:0]    out_rd,
  output logic [F3_W-1:0]      out_funct3,
  output logic [F7_W-1:0]      out_funct7,
  output logic                 out_is_write,
  output logic                 out_is_branch,
  output logic                 out_is_jump,
  output logic                 out_is_mem_read,
  output logic                 out_is_mem_write,
  output logic                 out_is_illegal,
  output logic [CNT_WIDTH-1:0] stall_count
);

  if (WORD_SIZE != 32) begin : g_bad_word_size
    $error("decode_pipe: only WORD_SIZE=32 is supported");
  end

  logic [OP_W-1:0]      opcode;
  instr_type_t          dec_type;
  logic [XLEN-1:0]      dec_imm;
  decoded_t             dec;
  logic                 is_sys;
  logic                 uses_rs1;
  logic                 uses_rs2;
  logic                 hazard_c;
  logic                 accept_c;

  decoded_t             bundle_q, bundle_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign opcode   = in_instr[6:0];
  assign dec_type = opcode_type(opcode);

  imm_gen u_imm_gen (
    .instr_i (in_instr),
    .type_i  (dec_type),
    .imm_o   (dec_imm)
  );

  // Field extraction and control decode for the incoming instruction.
  always_comb begin
    dec          = '0;
    is_sys       = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);
    dec.itype    = dec_type;
    dec.imm      = dec_imm;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.rd       = in_instr[11:7];
    dec.funct3   = in_instr[14:12];
    case (dec_type)
      TYPE_R: begin
        dec.funct7   = in_instr[31:25];
        dec.is_write = 1'b1;
      end
      TYPE_I: begin
        dec.rs2      = '0;
        dec.is_write = !is_sys;
        dec.is_jump  = (opcode == OP_JALR);
      end
      TYPE_I_MEM: begin
        dec.rs2         = '0;
        dec.is_write    = 1'b1;
        dec.is_mem_read = 1'b1;
      end
      TYPE_S: begin
        dec.rd           = '0;
        dec.is_mem_write = 1'b1;
      end
      TYPE_B: begin
        dec.rd        = '0;
        dec.is_branch = 1'b1;
      end
      TYPE_U: begin
        dec.rs1      = '0;
        dec.rs2      = '0;
        dec.funct3   = '0;
        dec.is_write = 1'b1;
      end
      TYPE_J: begin
        dec.rs1      = '0;
        dec.rs2      = '0;
        dec.funct3   = '0;
        dec.is_write = 1'b1;
        dec.is_jump  = 1'b1;
      end
      default: begin
        dec.rs2        = '0;
        dec.rd         = '0;
        dec.funct3     = '0;
        dec.is_illegal = 1'b1;
      end
    endcase
    if (dec.rd == '0) dec.is_write = 1'b0;
  end

  assign uses_rs1 = (dec_type == TYPE_R) || (dec_type == TYPE_I) || (dec_type == TYPE_I_MEM) ||
                    (dec_type == TYPE_S) || (dec_type == TYPE_B);
  assign uses_rs2 = (dec_type == TYPE_R) || (dec_type == TYPE_S) || (dec_type == TYPE_B);

  // Load in the output slot whose result the incoming instruction needs.
  if (HAZARD_DETECT != 0) begin : g_hazard
    assign hazard_c = in_valid && valid_q && bundle_q.is_mem_read && (bundle_q.rd != '0) &&
                      ((uses_rs1 && (dec.rs1 == bundle_q.rd)) ||
                       (uses_rs2 && (dec.rs2 == bundle_q.rd)));
  end else begin : g_no_hazard
    assign hazard_c = 1'b0;
  end

  assign in_ready = (!valid_q || out_ready) && !hazard_c && !flush;
  assign accept_c = in_valid && in_ready;

  // Output slot update: flush wins, then accept, then drain.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      pc_d     = in_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (!flush && hazard_c && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = pc_q;
  assign out_type         = bundle_q.itype;
  assign out_imm          = WORD_SIZE'(bundle_q.imm);
  assign out_rs1          = bundle_q.rs1;
  assign out_rs2          = bundle_q.rs2;
  assign out_rd           = bundle_q.rd;
  assign out_funct3       = bundle_q.funct3;
  assign out_funct7       = bundle_q.funct7;
  assign out_is_write     = bundle_q.is_write;
  assign out_is_branch    = bundle_q.is_branch;
  assign out_is_jump      = bundle_q.is_jump;
  assign out_is_mem_read  = bundle_q.is_mem_read;
  assign out_is_mem_write = bundle_q.is_mem_write;
  assign out_is_illegal   = bundle_q.is_illegal;
  assign stall_count      = cnt_q;

  a_hold_stable: assert property (@(posedge clock) disable iff (reset)
    (valid_q && !out_ready && !flush) |=> (valid_q && $stable(bundle_q) && $stable(pc_q)));
  a_no_accept_on_flush: assert property (@(posedge clock) disable iff (reset)
    flush |-> !in_ready);

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: directed RV32I vectors plus a random stream.
module tb_decode_pipe;
  import decode_pkg::*;

  localparam int unsigned PCW = 32;
  localparam int unsigned CW  = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  ty;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  ctl;   // write, branch, jump, mem_read, mem_write, illegal
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [PCW-1:0] in_pc, out_pc;
  instr_type_t out_type;
  logic [31:0] out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [2:0] out_funct3;
  logic [6:0] out_funct7;
  logic out_is_write, out_is_branch, out_is_jump, out_is_mem_read, out_is_mem_write, out_is_illegal;
  logic [CW-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  decode_pipe #(.WORD_SIZE(32), .PC_WIDTH(PCW), .HAZARD_DETECT(1), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_type(out_type), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_is_write(out_is_write), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_mem_read(out_is_mem_read),
    .out_is_mem_write(out_is_mem_write), .out_is_illegal(out_is_illegal),
    .stall_count(stall_count)
  );

  // Reference decode, organised per opcode with arithmetic sign extension.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic w, br, jp, mr, mw, il;
    e = '0; w = 0; br = 0; jp = 0; mr = 0; mw = 0; il = 0;
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = i[14:12];
    case (i[6:0])
      7'h03: begin e.ty = 4'd3; e.imm = 32'($signed(i[31:20])); e.rs2 = 0; w = 1; mr = 1; end
      7'h13: begin e.ty = 4'd2; e.imm = 32'($signed(i[31:20])); e.rs2 = 0; w = 1; end
      7'h67: begin e.ty = 4'd2; e.imm = 32'($signed(i[31:20])); e.rs2 = 0; w = 1; jp = 1; end
      7'h0F, 7'h73: begin e.ty = 4'd2; e.imm = 32'($signed(i[31:20])); e.rs2 = 0; end
      7'h33: begin e.ty = 4'd1; e.f7 = i[31:25]; w = 1; end
      7'h23: begin e.ty = 4'd4; e.imm = 32'($signed({i[31:25], i[11:7]})); e.rd = 0; mw = 1; end
      7'h63: begin
        e.ty = 4'd5; e.rd = 0; br = 1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin e.ty = 4'd6; e.imm = i & 32'hFFFF_F000; e.rs1 = 0; e.rs2 = 0; e.f3 = 0; w = 1; end
      7'h6F: begin
        e.ty = 4'd7; e.rs1 = 0; e.rs2 = 0; e.f3 = 0; w = 1; jp = 1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      default: begin e.ty = 4'd0; e.rs2 = 0; e.rd = 0; e.f3 = 0; il = 1; end
    endcase
    if (e.rd == 0) w = 0;
    e.ctl = {w, br, jp, mr, mw, il};
    return e;
  endfunction

  // Pop/compare what leaves the output slot, push what enters it (sampled mid-cycle).
  task automatic sb_sample();
    exp_t exp_v, act;
    if (reset) begin
      sb.delete();
      return;
    end
    if (out_valid && (out_ready || flush)) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected: output pc=%h with empty scoreboard", out_pc);
      end else begin
        exp_v = sb.pop_front();
        if (!flush) begin
          act = '{pc: out_pc, ty: 4'(out_type), imm: out_imm, rs1: out_rs1, rs2: out_rs2,
                  rd: out_rd, f3: out_funct3, f7: out_funct7,
                  ctl: {out_is_write, out_is_branch, out_is_jump, out_is_mem_read,
                        out_is_mem_write, out_is_illegal}};
          n_vec++;
          if (act !== exp_v) begin
            n_err++;
            $display("FAIL sb_bundle: got %h want %h", act, exp_v);
          end
        end
      end
    end
    if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
  endtask

  task automatic tick();
    @(negedge clock);
    sb_sample();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v; in_instr = ins; in_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if ({out_valid, 4'(out_type), stall_count} !== {1'b0, 4'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_init: got v=%b t=%0d s=%0d want 0/0/0", out_valid, out_type, stall_count);
    end
    reset = 0;
    drive(1, 32'h00500093, 32'h40);
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_prefill: out_valid got %b want 1", out_valid);
    end
    in_valid = 0;
    #2 reset = 1;
    #1;
    n_vec++;
    if ({out_valid, out_pc, 4'(out_type), out_imm, out_rs1, out_rs2, out_rd, out_funct3,
         out_funct7, out_is_write, out_is_branch, out_is_jump, out_is_mem_read,
         out_is_mem_write, out_is_illegal, stall_count} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b pc=%h t=%0d imm=%h rd=%0d want all zero",
               out_valid, out_pc, out_type, out_imm, out_rd);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_formats();
    out_ready = 1;
    drive(1, 32'h00500093, 32'h100);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL fmt_ready: got %b want 1", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, 4'(out_type), out_imm, out_rd, out_is_write} !== {1'b1, 4'd2, 32'd5, 5'd1, 1'b1}) begin
      n_err++;
      $display("FAIL fmt_addi: got t=%0d imm=%h rd=%0d w=%b want 2/5/1/1", out_type, out_imm, out_rd, out_is_write);
    end
    drive(1, 32'h123452B7, 32'h104);
    tick();
    n_vec++;
    if ({4'(out_type), out_imm, out_rs1, out_rd} !== {4'd6, 32'h12345000, 5'd0, 5'd5}) begin
      n_err++;
      $display("FAIL fmt_lui: got t=%0d imm=%h rs1=%0d rd=%0d want 6/12345000/0/5", out_type, out_imm, out_rs1, out_rd);
    end
    drive(1, 32'h0020A423, 32'h108);
    tick();
    n_vec++;
    if ({4'(out_type), out_imm, out_rd, out_rs1, out_rs2, out_is_mem_write, out_is_write} !==
        {4'd4, 32'd8, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fmt_sw: got t=%0d imm=%h rd=%0d mw=%b want 4/8/0/1", out_type, out_imm, out_rd, out_is_mem_write);
    end
    drive(1, 32'hFFDFF0EF, 32'h10C);
    tick();
    n_vec++;
    if ({4'(out_type), out_imm, out_is_jump, out_rd, out_rs1} !== {4'd7, 32'hFFFFFFFC, 1'b1, 5'd1, 5'd0}) begin
      n_err++;
      $display("FAIL fmt_jal: got t=%0d imm=%h j=%b want 7/fffffffc/1", out_type, out_imm, out_is_jump);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_load_use();
    out_ready = 1;
    drive(1, 32'h0000A103, 32'h200);
    tick();
    drive(1, 32'h002101B3, 32'h204);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL hz_ready: got %b want 0", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, stall_count, in_ready} !== {1'b0, 16'd1, 1'b1}) begin
      n_err++;
      $display("FAIL hz_bubble: got v=%b s=%0d r=%b want 0/1/1", out_valid, stall_count, in_ready);
    end
    tick();
    n_vec++;
    if ({out_valid, 4'(out_type), out_rd, out_pc} !== {1'b1, 4'd1, 5'd3, 32'h204}) begin
      n_err++;
      $display("FAIL hz_add: got v=%b t=%0d rd=%0d pc=%h want 1/1/3/204", out_valid, out_type, out_rd, out_pc);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(1, 32'h00500093, 32'h300);
    tick();
    drive(1, 32'h00000000, 32'h304);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_pc, 4'(out_type), out_imm, out_rd, out_is_write} !==
          {1'b0, 1'b1, 32'h300, 4'd2, 32'd5, 5'd1, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got r=%b v=%b pc=%h imm=%h want 0/1/300/5", k, in_ready, out_valid, out_pc, out_imm);
      end
      tick();
    end
    out_ready = 1;
    tick();
    n_vec++;
    if ({out_valid, 4'(out_type), out_is_illegal, out_is_write, out_imm} !== {1'b1, 4'd0, 1'b1, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL bp_illegal: got v=%b t=%0d il=%b w=%b want 1/0/1/0", out_valid, out_type, out_is_illegal, out_is_write);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1;
    flush = 1;
    drive(1, 32'h00500093, 32'h400);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", in_ready); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_noaccept: out_valid got %b want 0", out_valid); end
    flush = 0;
    drive(1, 32'h0000A103, 32'h404);
    tick();
    drive(1, 32'h002101B3, 32'h408);
    flush = 1;
    tick();
    n_vec++;
    if ({out_valid, stall_count} !== {1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL fl_hazard: got v=%b s=%0d want 0/1", out_valid, stall_count);
    end
    flush = 0;
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{OP_LOAD, OP_IMM, OP_JALR, OP_REG, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
            OP_JAL, OP_SYSTEM, 7'b0000000, 7'b1111110};
    for (int c = 0; c < 400; c++) begin
      w = $urandom();
      w[6:0]   = ops[$urandom_range(0, 11)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) != 0), w, 32'(c * 4));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (3) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rnd_drain: %0d entries left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
